// File: rtl/nbit_serial_addsub_if.sv
// ---------------------------------------------------------------------------
// nbit_serial_addsub_if
// Request/result bundle for the serial add/subtract unit.
//
// Handshake: the master raises start together with sub/a/b. The unit samples
// them only while idle (busy=0, done=0). busy stays high for the whole serial
// pass. done pulses high for exactly one cycle when r/f carry the new result.
// start is ignored while busy or done is high, and nothing is queued.
// r/f hold the last completed result until the next one completes.
//
// Parameter: N - operand/result width.
// Signals  : start, sub, a[N-1:0], b[N-1:0]  (master -> unit)
//            busy, done, r[N-1:0], f[3:0]     (unit -> master)
// Modports : master (requester side), slave (the unit).
// ---------------------------------------------------------------------------
interface nbit_serial_addsub_if #(
   parameter int N = 4
);
   logic         start;
   logic         sub;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] r;
   logic [3:0]   f;

   modport master (
      output start, sub, a, b,
      input  busy, done, r, f
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, r, f
   );
endinterface

// File: rtl/nbit_serial_addsub.sv
// ---------------------------------------------------------------------------
// nbit_serial_addsub
// Multi-cycle N-bit adder/subtractor that processes CHUNK bits per clock and
// reports N/Z/C/V flags on the N-bit result.
//
// Parameters: N     - operand/result width (N >= 2)
//             CHUNK - bits added per clock (N must be a multiple of CHUNK)
// Ports     : clk       - rising-edge clock
//             rst       - asynchronous active-high reset
//             bus       - nbit_serial_addsub_if.slave (start/sub/a/b in,
//                         busy/done/r/f out)
//             dbg_state - current FSM state (0=IDLE, 1=RUN, 2=DONE)
// Flags     : f[3]=N, f[2]=Z, f[1]=C (carry out; for subtraction 1 = no
//             borrow), f[0]=V (signed overflow).
// Optional  : define NBIT_ADDSUB_SAT_EN to saturate r to the signed extreme
//             on overflow. C and V still describe the raw operation; N and Z
//             describe the saturated r.
// ---------------------------------------------------------------------------
module nbit_serial_addsub #(
   parameter int N     = 4,
   parameter int CHUNK = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   nbit_serial_addsub_if.slave  bus,
   output logic [1:0]           dbg_state
);

   localparam int NCH = N / CHUNK;
   localparam int CW  = $clog2(NCH + 1);

   generate
      if (N < 2 || CHUNK < 1 || (N % CHUNK) != 0) begin : g_bad_params
         $error("nbit_serial_addsub: N must be >= 2 and a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    op_a_q, op_a_d;
   logic [N-1:0]    op_b_q, op_b_d;     // already inverted for subtraction
   logic            carry_q, carry_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    acc_q, acc_d;       // internal shift register, not r
   logic [N-1:0]    r_q, r_d;
   logic [3:0]      f_q, f_d;

   logic [CHUNK:0]  chunk_sum;
   logic [N-1:0]    acc_shift;
   logic            msb_a, msb_b, msb_s;
   logic            ovf;
   logic [N-1:0]    res_final;

   // Current chunk sum; the top bit is the carry into the next chunk.
   assign chunk_sum = {1'b0, op_a_q[CHUNK-1:0]} + {1'b0, op_b_q[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_q};

   // New sum chunk enters from the MSB side; after NCH steps the first chunk
   // has reached bit 0.
   assign acc_shift = (acc_q >> CHUNK) | (N'(chunk_sum[CHUNK-1:0]) << (N - CHUNK));

   // On the last step the chunk's top bit is the operand MSB. Overflow when
   // both operands share a sign that the sum does not (equivalent to carry
   // into MSB xor carry out of MSB).
   assign msb_a = op_a_q[CHUNK-1];
   assign msb_b = op_b_q[CHUNK-1];
   assign msb_s = chunk_sum[CHUNK-1];
   assign ovf   = ~(msb_a ^ msb_b) & (msb_s ^ msb_a);

`ifdef NBIT_ADDSUB_SAT_EN
   // On overflow the true result has A's sign, so clamp toward that extreme.
   assign res_final = ovf ? (msb_a ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                          : acc_shift;
`else
   assign res_final = acc_shift;
`endif

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      r_d     = r_q;
      f_d     = f_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_a_d  = bus.a;
               op_b_d  = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub;           // +1 completes two's complement
               cnt_d   = '0;
               acc_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            op_a_d  = op_a_q >> CHUNK;
            op_b_d  = op_b_q >> CHUNK;
            carry_d = chunk_sum[CHUNK];
            acc_d   = acc_shift;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(NCH - 1)) begin
               r_d     = res_final;
               f_d     = {res_final[N-1], (res_final == '0), chunk_sum[CHUNK], ovf};
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         r_q     <= '0;
         f_q     <= '0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         r_q     <= r_d;
         f_q     <= f_d;
      end
   end

   assign bus.busy  = (state_q == ST_RUN);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.r     = r_q;
   assign bus.f     = f_q;
   assign dbg_state = state_q;

endmodule
